// File: rtl/uart_rx_deser.sv
// uart_rx_deser -- 8N1 UART receive front end (LSB first).
//
// Synchronizes the asynchronous serial line, finds the start bit, samples
// every bit in the middle of its bit period and presents each well-framed
// byte with a one-cycle strobe. A low stop bit raises a one-cycle frame
// error and parks the receiver until the line returns high.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit; must be even and >= 4
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   rx_serial  asynchronous serial input, idles high
//   rx_byte    last correctly framed byte, held between frames
//   rx_stb     one-cycle pulse: rx_byte has just been updated
//   frame_err  one-cycle pulse: stop bit sampled low
//   busy       high whenever the receiver is not idle
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_stb,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state, state_n;
    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] cyc, cyc_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    sh, sh_n;
    logic [7:0]    byte_n;
    logic          stb_n, ferr_n;
    logic          cyc_done, half_done, bit_last;

    assign rx_s      = sync[1];
    assign cyc_done  = (cyc == CNT_LAST);
    assign half_done = (cyc == CNT_HALF);
    assign bit_last  = (bit_cnt == 3'd7);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Sync flops reset high so reset never looks like a start bit.
            sync      <= 2'b11;
            state     <= IDLE;
            cyc       <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            rx_byte   <= '0;
            rx_stb    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], rx_serial};
            state     <= state_n;
            cyc       <= cyc_n;
            bit_cnt   <= bit_n;
            sh        <= sh_n;
            rx_byte   <= byte_n;
            rx_stb    <= stb_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        bit_n   = bit_cnt;
        sh_n    = sh;
        byte_n  = rx_byte;
        stb_n   = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                cyc_n = '0;
                bit_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (half_done) begin
                    // High at mid start bit means a glitch: drop it silently.
                    cyc_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cyc_n = cyc + CW'(1);
                end
            end
            DATA: begin
                if (cyc_done) begin
                    cyc_n = '0;
                    sh_n  = {rx_s, sh[7:1]};   // LSB first: shift right
                    if (bit_last) begin
                        bit_n   = '0;
                        state_n = STOP;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end else begin
                    cyc_n = cyc + CW'(1);
                end
            end
            STOP: begin
                if (cyc_done) begin
                    cyc_n = '0;
                    if (rx_s) begin
                        byte_n  = sh;
                        stb_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cyc_n = cyc + CW'(1);
                end
            end
            BREAK: begin
                // A held-low line must go high before a new start is accepted.
                cyc_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cyc_n   = '0;
                bit_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
module tb_uart_rx_deser;

    localparam int N = 16;
    localparam int H = N / 2;
    // From the negedge that drives the start bit to the negedge where the
    // pulse is visible: 2 sync cycles + H + 9N + 1 registered output.
    localparam int LAT = 3 + H + 9 * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_stb, frame_err, busy;

    uart_rx_deser #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .rx_byte   (rx_byte),
        .rx_stb    (rx_stb),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    typedef struct {
        logic        err;
        logic [7:0]  data;
        int unsigned at;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_good = 8'h00;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, ncyc);
        end
    endfunction

    // Monitor: every pulse must match the oldest outstanding expectation.
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_stb && frame_err) chk("pulse_exclusive", 32'd1, 32'd0);
            if ((rx_stb || frame_err) && prev_pulse) chk("pulse_width", 32'd2, 32'd1);
            if (rx_stb || frame_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, frame_err, rx_stb}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
                    chk("pulse_stb", {31'd0, rx_stb}, {31'd0, !e.err});
                    chk("rx_byte", {24'd0, rx_byte}, {24'd0, e.data});
                    chk("pulse_time", ncyc, e.at);
                end
            end else if (q.size() > 0 && ncyc > q[0].at) begin
                exp_t e;
                e = q.pop_front();
                chk("missed_pulse", ncyc, e.at);
            end
        end
        prev_pulse = rx_stb || frame_err;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_serial = 1'b1;
        end
    endtask

    // Drive one frame; rst_bit >= 0 pulses rst mid data bit rst_bit.
    task automatic send_frame(input logic [7:0] b, input logic stopv, input int rst_bit);
        logic [9:0] bits;
        bits = {stopv, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < N; k++) begin
                @(negedge clk);
                if (k == 0) rx_serial = bits[i];
                if (i == 0 && k == 0 && rst_bit < 0) begin
                    q.push_back('{err: !stopv, data: stopv ? b : last_good, at: ncyc + LAT});
                    if (stopv) last_good = b;
                end
                if (rst_bit >= 0 && i == rst_bit + 1) begin
                    if (k == H) rst = 1'b1;
                    if (k == H + 1) begin
                        rst = 1'b0;
                        last_good = 8'h00;
                        chk("mid_rst_byte", {24'd0, rx_byte}, 32'd0);
                        chk("mid_rst_stb", {31'd0, rx_stb}, 32'd0);
                        chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
                        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
                    end
                end
            end
        end
    endtask

    initial begin
        int unsigned t0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("rst_byte", {24'd0, rx_byte}, 32'd0);
        chk("rst_stb", {31'd0, rx_stb}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        idle(4);

        // Single byte
        send_frame(8'h11, 1'b1, -1);
        idle(2 * N);

        // Back-to-back, no idle gap
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hA5, 1'b1, -1);
        send_frame(8'hAF, 1'b1, -1);
        send_frame(8'hAF, 1'b1, -1);
        send_frame(8'hAF, 1'b1, -1);
        send_frame(8'hF0, 1'b1, -1);
        idle(2 * N);

        // Glitch: 4 low cycles
        @(negedge clk);
        t0 = ncyc;
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rx_serial = 1'b1;
        while (ncyc < t0 + 3) @(negedge clk);
        chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
        while (ncyc < t0 + 3 + H) @(negedge clk);
        chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
        idle(2 * N);
        send_frame(8'h3C, 1'b1, -1);
        idle(2 * N);

        // Framing error, then line held low 40 more bit times
        send_frame(8'h81, 1'b0, -1);
        repeat (40 * N) @(negedge clk);
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("break_byte", {24'd0, rx_byte}, {24'd0, last_good});
        idle(2 * N);
        chk("break_exit_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h3C, 1'b1, -1);
        idle(2 * N);

        // Reset during data bit 4 of 0xF0, then a clean 0x0F
        send_frame(8'hF0, 1'b1, 4);
        idle(2 * N);
        send_frame(8'h0F, 1'b1, -1);
        idle(2 * N);
        chk("final_byte", {24'd0, rx_byte}, 32'h0F);
        chk("final_busy", {31'd0, busy}, 32'd0);
        chk("pending_expect", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
